// File: rtl/pulse_train_tx.sv
// Burst generator of low-going pulses on data_out with programmable low/high widths,
// a forced-high gap after the burst, and a one-cycle done strobe.
module pulse_train_tx #(
    parameter int unsigned LOW_CYC  = 8,
    parameter int unsigned HIGH_CYC = 8,
    parameter int unsigned GAP_CYC  = 64,
    parameter int unsigned TIMER_W  = 16
) (
    input  logic       pll_inst1_CLKOUT0,
    input  logic [1:0] BTN,
    input  logic [3:0] burst_len,
    output logic       data_out,
    output logic       busy,
    output logic       done,
    output logic [3:0] LED,
    output logic       clk_out
);

    localparam logic [TIMER_W-1:0] TIMER_LOW  = TIMER_W'(LOW_CYC - 1);
    localparam logic [TIMER_W-1:0] TIMER_HIGH = TIMER_W'(HIGH_CYC - 1);
    localparam logic [TIMER_W-1:0] TIMER_GAP  = TIMER_W'(GAP_CYC - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_GAP,
        S_DONE
    } state_t;

    logic clk;
    logic rst_n;
    logic start_btn;

    assign clk       = pll_inst1_CLKOUT0;
    assign rst_n     = BTN[0];
    assign start_btn = BTN[1];

    state_t             state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic [3:0]         remaining, remaining_nxt;
    logic [3:0]         led_nxt;
    logic [1:0]         sync_q;
    logic               sync_d;
    logic               start_p;

    // Start pushbutton: two-flop synchroniser plus registered rising-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            sync_d  <= 1'b0;
            start_p <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], start_btn};
            sync_d  <= sync_q[1];
            start_p <= sync_q[1] & ~sync_d;
        end
    end

    // Next-state, timer, pulse count and remaining-pulse bookkeeping
    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        remaining_nxt = remaining;
        led_nxt       = LED;
        case (state)
            S_IDLE: begin
                if (start_p) begin
                    remaining_nxt = burst_len;
                    led_nxt       = 4'd0;
                    if (burst_len == 4'd0) begin
                        state_nxt = S_GAP;
                        timer_nxt = TIMER_GAP;
                    end else begin
                        state_nxt = S_LOW;
                        timer_nxt = TIMER_LOW;
                    end
                end
            end
            S_LOW: begin
                if (timer == '0) begin
                    led_nxt       = LED + 4'd1;
                    remaining_nxt = remaining - 4'd1;
                    timer_nxt     = TIMER_HIGH;
                    state_nxt     = S_HIGH;
                end else begin
                    timer_nxt = timer - TIMER_ONE;
                end
            end
            S_HIGH: begin
                if (timer == '0) begin
                    if (remaining == 4'd0) begin
                        state_nxt = S_GAP;
                        timer_nxt = TIMER_GAP;
                    end else begin
                        state_nxt = S_LOW;
                        timer_nxt = TIMER_LOW;
                    end
                end else begin
                    timer_nxt = timer - TIMER_ONE;
                end
            end
            S_GAP: begin
                if (timer == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    timer_nxt = timer - TIMER_ONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with the state flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            remaining <= 4'd0;
            LED       <= 4'd0;
            data_out  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            clk_out   <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            remaining <= remaining_nxt;
            LED       <= led_nxt;
            data_out  <= (state_nxt != S_LOW);
            busy      <= (state_nxt != S_IDLE);
            done      <= (state_nxt == S_DONE);
            clk_out   <= ~clk_out;
        end
    end

endmodule

// File: tb/tb_pulse_train_tx.sv
// Bench for pulse_train_tx: default and minimum-width instances share stimulus and are
// checked every cycle against an arithmetic waveform model.
module tb_pulse_train_tx;

    logic       clk = 1'b0;
    logic [1:0] btn;
    logic [3:0] burst_len;
    logic [1:0] d_o, busy_o, done_o, clk_o;
    logic [3:0] led_o [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pulse_train_tx u_nom (
        .pll_inst1_CLKOUT0(clk), .BTN(btn), .burst_len(burst_len),
        .data_out(d_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .LED(led_o[0]), .clk_out(clk_o[0])
    );

    pulse_train_tx #(.LOW_CYC(1), .HIGH_CYC(1), .GAP_CYC(1), .TIMER_W(4)) u_min (
        .pll_inst1_CLKOUT0(clk), .BTN(btn), .burst_len(burst_len),
        .data_out(d_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .LED(led_o[1]), .clk_out(clk_o[1])
    );

    int lowc  [2] = '{8, 1};
    int highc [2] = '{8, 1};
    int gapc  [2] = '{64, 1};

    // Model state: a burst is fully described by its start_p edge and its length
    int   edge_cnt = 0;
    int   press_edge = -100;
    int   last_rst = 0;
    bit   clk_exp = 1'b0;
    bit   started [2] = '{1'b0, 1'b0};
    int   s_edge [2] = '{0, 0};
    int   n [2] = '{0, 0};
    int   led_last [2] = '{0, 0};
    int   falls [2] = '{0, 0};
    int   done_cnt [2] = '{0, 0};
    int   done_edge [2] = '{0, 0};
    bit   prev_d [2] = '{1'b1, 1'b1};
    int   tot_m;
    int   p_c, tot_c, j_c, ph_c, ed, eb, edn, el;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        edge_cnt++;
        if (!btn[0]) begin
            last_rst = edge_cnt;
            clk_exp  = 1'b0;
            for (int i = 0; i < 2; i++) begin
                started[i]  = 1'b0;
                led_last[i] = 0;
            end
        end else begin
            clk_exp = ~clk_exp;
            for (int i = 0; i < 2; i++) begin
                tot_m = n[i] * (lowc[i] + highc[i]) + gapc[i] + 1;
                if (edge_cnt == press_edge + 3 && press_edge > last_rst &&
                    (!started[i] || edge_cnt > s_edge[i] + tot_m)) begin
                    if (started[i]) led_last[i] = n[i];
                    started[i] = 1'b1;
                    s_edge[i]  = edge_cnt;
                end
                if (started[i] && edge_cnt == s_edge[i] + 1) n[i] = int'(burst_len);
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!btn[0]) begin
                ed = 1; eb = 0; edn = 0; el = 0;
            end else begin
                p_c   = lowc[i] + highc[i];
                tot_c = n[i] * p_c + gapc[i] + 1;
                j_c   = edge_cnt - s_edge[i];
                if (started[i] && j_c >= 1 && j_c <= tot_c) begin
                    eb  = 1;
                    edn = (j_c == tot_c) ? 1 : 0;
                    if (j_c <= n[i] * p_c) begin
                        ph_c = (j_c - 1) % p_c;
                        ed   = (ph_c >= lowc[i]) ? 1 : 0;
                        el   = (j_c - 1) / p_c + ((ph_c >= lowc[i]) ? 1 : 0);
                    end else begin
                        ed = 1;
                        el = n[i];
                    end
                end else begin
                    ed = 1; eb = 0; edn = 0;
                    el = (started[i] && j_c > tot_c) ? n[i] : led_last[i];
                end
            end
            check($sformatf("data_out[%0d]", i), int'(d_o[i]), ed);
            check($sformatf("busy[%0d]", i), int'(busy_o[i]), eb);
            check($sformatf("done[%0d]", i), int'(done_o[i]), edn);
            check($sformatf("LED[%0d]", i), int'(led_o[i]), el);
            check($sformatf("clk_out[%0d]", i), int'(clk_o[i]), btn[0] ? int'(clk_exp) : 0);

            // Loopback falling-edge counter, compared at each done strobe
            if (!btn[0]) falls[i] = 0;
            else if (prev_d[i] && !d_o[i]) falls[i]++;
            prev_d[i] = d_o[i];
            if (done_o[i]) begin
                check($sformatf("falls[%0d]", i), falls[i], n[i]);
                falls[i] = 0;
                done_cnt[i]++;
                done_edge[i] = edge_cnt;
            end
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic press();
        btn[1]     = 1'b1;
        press_edge = edge_cnt;
        step(4);
        btn[1]     = 1'b0;
    endtask

    task automatic wait_idle();
        int c;
        step(8);
        c = 0;
        while (busy_o != 2'b00 && c < 3000) begin
            step(1);
            c++;
        end
        check("idle_timeout", int'(busy_o != 2'b00), 0);
        step(3);
    endtask

    int st, dc0;

    initial begin
        btn       = 2'b00;
        burst_len = 4'd0;

        // Reset held while the start button toggles
        for (int k = 0; k < 6; k++) begin
            step(1);
            btn[1] = ~btn[1];
        end
        btn[1] = 1'b0;
        step(2);
        btn[0] = 1'b1;
        step(2);

        // Nominal burst of 5; burst_len changed mid-burst must not matter
        burst_len = 4'd5;
        press();
        st = press_edge + 3;
        step(20);
        burst_len = 4'd9;
        wait_idle();
        check("nom_done_latency", done_edge[0] - st, 145);
        check("min_done_latency", done_edge[1] - st, 12);
        check("nom_led_final", int'(led_o[0]), 5);
        check("min_led_final", int'(led_o[1]), 5);

        // Zero-length burst: gap only
        burst_len = 4'd0;
        press();
        st = press_edge + 3;
        wait_idle();
        check("zero_done_latency", done_edge[0] - st, 65);
        check("zero_min_latency", done_edge[1] - st, 2);
        check("zero_led", int'(led_o[0]), 0);

        // Presses mid-burst and in the DONE cycle are dropped
        burst_len = 4'd3;
        press();
        st  = press_edge + 3;
        dc0 = done_cnt[0];
        step(26);
        press();
        while (edge_cnt < st + 110) step(1);
        press();
        wait_idle();
        check("ignore_done_count", done_cnt[0] - dc0, 1);
        check("ignore_done_latency", done_edge[0] - st, 113);

        // Press after done restarts with LED cleared
        press();
        st = press_edge + 3;
        step(2);
        check("restart_led_cleared", int'(led_o[0]), 0);
        step(16);
        check("restart_led_one", int'(led_o[0]), 1);
        wait_idle();

        // Reset during the second low phase
        burst_len = 4'd4;
        press();
        st = press_edge + 3;
        while (edge_cnt < st + 18) step(1);
        check("second_low_active", int'(d_o[0]), 0);
        btn[0] = 1'b0;
        #1;
        check("rst_async_data_out", int'(d_o[0]), 1);
        check("rst_async_led", int'(led_o[0]), 0);
        check("rst_async_busy", int'(busy_o[0]), 0);
        step(3);
        btn[0] = 1'b1;
        step(40);
        check("post_rst_idle", int'(busy_o[0]), 0);

        // Longest burst on both instances
        burst_len = 4'd15;
        press();
        st = press_edge + 3;
        wait_idle();
        check("max_min_latency", done_edge[1] - st, 32);
        check("max_min_led", int'(led_o[1]), 15);
        check("max_nom_latency", done_edge[0] - st, 305);
        check("max_nom_led", int'(led_o[0]), 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_train_tx.md
Name: pulse_train_tx

Overview:
Transmit-side companion to the bench's falling-edge pulse counter. On a start request it drives a burst of N low-going pulses on data_out, with programmable low and high widths. After the burst it enforces an idle gap and then signals completion. It sits on the FPGA bench top and is looped, via pin or wire, into the counter's data_in so that LED counts can be checked against the transmitted count.

Parameters:
LOW_CYC, 8, clock cycles data_out is held low per pulse (>=1)
HIGH_CYC, 8, clock cycles data_out is held high after each low phase (>=1)
GAP_CYC, 64, clock cycles of forced-high holdoff after the last pulse, before done (>=1)
TIMER_W, 16, width of the phase timer; must hold max(LOW_CYC, HIGH_CYC, GAP_CYC)

Ports:
pll_inst1_CLKOUT0  input  1  sole clock, from the PLL; all flops on rising edge
BTN  input  2  BTN[0] = reset, asynchronous, active-low; BTN[1] = start pushbutton, asynchronous, active-high
burst_len  input  4  number of pulses to send; sampled when start is accepted
data_out  output  1  pulse line; idle high
busy  output  1  high from start acceptance until done is asserted
done  output  1  one-cycle strobe at burst completion
LED  output  4  count of pulses sent in the current or last burst
clk_out  output  1  pll_inst1_CLKOUT0/2 scope reference

Behaviour:
- Reset: BTN[0]=0 asynchronously forces the following. State=IDLE, data_out=1, busy=0, done=0, LED=0, clk_out=0, timer=0, remaining=0, synchroniser flops=0.
- Reset release is synchronous in effect: flops leave reset on the first rising edge after BTN[0]=1.
- Reset mid-burst aborts the burst immediately and data_out returns high asynchronously.
- clk_out: toggles every rising edge while out of reset.
- Start path: BTN[1] passes through a 2-flop synchroniser, then a rising-edge detector register. start_p is a one-cycle pulse asserted 3 edges after BTN[1] rises.
- start_p is honoured only in IDLE. In any other state it is dropped and not queued.
- State machine: IDLE -> LOW -> HIGH -> (LOW | GAP) -> DONE -> IDLE.
  - IDLE, on start_p: latch remaining=burst_len, clear LED to 0, set busy=1. If burst_len=0, go to GAP; otherwise go to LOW with timer=LOW_CYC-1.
  - LOW: data_out=0. Timer decrements each cycle. At timer=0: LED<=LED+1, remaining<=remaining-1, timer<=HIGH_CYC-1, go to HIGH.
  - HIGH: data_out=1. At timer=0: if remaining=0, go to GAP with timer=GAP_CYC-1; otherwise go to LOW with timer=LOW_CYC-1.
  - GAP: data_out=1. At timer=0, go to DONE.
  - DONE: done=1 for exactly this cycle, busy<=0, go to IDLE. A start_p arriving in the DONE cycle is ignored.
- data_out is driven straight from a state flop (registered, glitch-free). Its first falling edge occurs on the clock edge after the start_p cycle.
- Per-pulse timing: each low phase lasts exactly LOW_CYC cycles and each high phase exactly HIGH_CYC cycles.
- Falling edges per burst: exactly burst_len. Pulse period = LOW_CYC+HIGH_CYC.
- LED increments when a low phase ends. It wraps 4-bit only through a reset or restart. burst_len is at most 15, so it never overflows within a burst.
- LED holds its final value after done until the next accepted start.
- busy = (state != IDLE).
- Burst duration from start_p to done: burst_len*(LOW_CYC+HIGH_CYC) + GAP_CYC + 1 cycles.
- Changing burst_len mid-burst has no effect.

Test Plan:
- Reset: hold BTN[0]=0 with BTN[1] toggling -> data_out=1, busy=0, done=0, LED=0, clk_out=0 throughout. clk_out toggles from the first edge after release.
- Nominal burst (defaults), burst_len=5, BTN[1] pulsed -> exactly 5 low pulses, each 8 cycles low and 8 high. LED steps 1..5. done strobes once, 5*16+64+1=145 cycles after start_p. A loopback falling-edge counter reads 5.
- burst_len=0 -> no low on data_out, busy high for 65 cycles, then done strobe. LED=0.
- Start ignored while busy: burst_len=3, second BTN[1] press mid-burst and another press in the DONE cycle -> exactly 3 pulses, single done. A press after done -> a new burst, with LED cleared to 0 then counting.
- Reset mid-pulse: assert BTN[0]=0 during the 2nd low phase of burst_len=4 -> data_out goes high asynchronously, LED=0, busy=0. After release, state is IDLE and no residual pulses are sent.
- Parameter corner: LOW_CYC=1, HIGH_CYC=1, GAP_CYC=1, burst_len=15 -> 15 one-cycle lows, period 2, LED=15, done 32 cycles after start_p.
